// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op modes, default geometry,
// and the helpers that derive the slice width and check the width/depth pairing.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  function automatic int slice_width(input int width, input int stages);
    return (stages >= 1) ? (width / stages) : width;
  endfunction

  function automatic bit width_ok(input int width, input int stages);
    return (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One registered SW-bit slice of the pipelined adder: sum, carry-out, carry into the
// slice MSB and the op's valid bit, all advancing only when en is high.
module adder_slice #(
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          valid_in,
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic          valid,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          cmsb
);

  logic [SW:0] full_s;
  logic        cmsb_s;

  // Slice add; carry into the MSB is recovered from the MSB sum bit.
  always_comb begin
    full_s = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
    cmsb_s = a[SW-1] ^ b[SW-1] ^ full_s[SW-1];
  end

  // Slice result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      sum   <= {SW{1'b0}};
      cout  <= 1'b0;
      cmsb  <= 1'b0;
    end else if (en) begin
      valid <= valid_in;
      sum   <= full_s[SW-1:0];
      cout  <= full_s[SW];
      cmsb  <= cmsb_s;
    end
  end

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit add/subtract, one carry-rippled slice per stage, valid/ready on both
// sides with a single global advance. Define ADDER_SAT_EN for signed saturation of SUM.
module adder_pipe_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero
);

  localparam int SW = slice_width(WIDTH, STAGES);

  if (!width_ok(WIDTH, STAGES)) begin : g_chk
    $error("adder_pipe_nbit: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;
  logic [WIDTH-1:0] raw_sum;
  logic             last_cout;
  logic             last_cmsb;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = (SUB == OP_SUB) ? ~B : B;
  assign cin0     = (SUB == OP_SUB) ? 1'b1 : C0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0] sl_a, sl_b, sl_sum;
    logic          sl_cin, sl_vin, sl_valid, sl_cout, sl_cmsb;

    if (k == 0) begin : g_in
      assign sl_a   = A[SW-1:0];
      assign sl_b   = b_eff[SW-1:0];
      assign sl_cin = cin0;
      assign sl_vin = in_valid;
    end else begin : g_in
      // a_up/b_up carry the not-yet-added operand bits; lo carries finished lower sum bits.
      localparam int UW = WIDTH - k * SW;
      logic [UW-1:0]     a_up, b_up, a_nxt, b_nxt;
      logic [k*SW-1:0]   lo, lo_nxt;

      if (k == 1) begin : g_src
        assign a_nxt  = A[WIDTH-1:SW];
        assign b_nxt  = b_eff[WIDTH-1:SW];
        assign lo_nxt = g_stage[0].sl_sum;
      end else begin : g_src
        assign a_nxt  = g_stage[k-1].g_in.a_up[UW+SW-1:SW];
        assign b_nxt  = g_stage[k-1].g_in.b_up[UW+SW-1:SW];
        assign lo_nxt = {g_stage[k-1].sl_sum, g_stage[k-1].g_in.lo};
      end

      // Skew and de-skew registers move in lockstep with the slices.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_up <= {UW{1'b0}};
          b_up <= {UW{1'b0}};
          lo   <= {(k*SW){1'b0}};
        end else if (adv) begin
          a_up <= a_nxt;
          b_up <= b_nxt;
          lo   <= lo_nxt;
        end
      end

      assign sl_a   = a_up[SW-1:0];
      assign sl_b   = b_up[SW-1:0];
      assign sl_cin = g_stage[k-1].sl_cout;
      assign sl_vin = g_stage[k-1].sl_valid;
    end

    adder_slice #(.SW(SW)) u_slice (
      .clk      (clk),
      .rst      (rst),
      .en       (adv),
      .valid_in (sl_vin),
      .a        (sl_a),
      .b        (sl_b),
      .cin      (sl_cin),
      .valid    (sl_valid),
      .sum      (sl_sum),
      .cout     (sl_cout),
      .cmsb     (sl_cmsb)
    );
  end

  if (STAGES == 1) begin : g_out
    assign raw_sum = g_stage[0].sl_sum;
  end else begin : g_out
    assign raw_sum = {g_stage[STAGES-1].sl_sum, g_stage[STAGES-1].g_in.lo};
  end

  assign out_valid = g_stage[STAGES-1].sl_valid;
  assign last_cout = g_stage[STAGES-1].sl_cout;
  assign last_cmsb = g_stage[STAGES-1].sl_cmsb;
  assign Cout      = last_cout;
  assign Overflow  = last_cmsb ^ last_cout;

  // Result select; flags above always describe the raw add.
  always_comb begin
    SUM = raw_sum;
`ifdef ADDER_SAT_EN
    if (Overflow) begin
      if (raw_sum[WIDTH-1]) begin
        SUM = {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        SUM = {1'b1, {(WIDTH-1){1'b0}}};
      end
    end else begin
      SUM = raw_sum;
    end
`endif
  end

  // Gated by valid so an idle or freshly reset unit reports Zero=0.
  assign Zero = out_valid && (SUM == {WIDTH{1'b0}});

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Scoreboard bench for adder_pipe_nbit: directed 32/4 vectors, stall, mid-stream reset,
// plus random streams on 8/1, 16/2 and 64/8 instances against a wide reference model.
module tb_adder_pipe_nbit;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic c0, input logic sub);
    logic [64:0] full;
    logic [63:0] mask, bb, s;
    logic        cin, as, bs, ss;
    exp_t        e;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    bb   = (sub ? ~b : b) & mask;
    cin  = sub ? 1'b1 : c0;
    full = {1'b0, a & mask} + {1'b0, bb} + {64'd0, cin};
    s    = full[63:0] & mask;
    as   = a[w-1];
    bs   = bb[w-1];
    ss   = s[w-1];
    e.cout = full[w];
    e.ovf  = (as == bs) && (ss != as);
`ifdef ADDER_SAT_EN
    if (e.ovf) s = ss ? (mask >> 1) : (mask & ~(mask >> 1));
`endif
    e.sum  = s;
    e.zero = (s == 64'd0);
    return e;
  endfunction

  function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o, input logic z);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.zero = z;
    return e;
  endfunction

`ifdef ADDER_SAT_EN
  localparam logic [31:0] T2_SUM = 32'h8000_0000;
  localparam logic [31:0] T3_SUM = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] T2_SUM = 32'h6730_78B8;
  localparam logic [31:0] T3_SUM = 32'h8000_0000;
`endif

  // ---------------- main 32/4 instance ----------------
  logic        rst, in_valid, in_ready, c0, sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] a, b, sum;
  exp_t        main_q[$];

  adder_pipe_nbit #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .C0(c0), .SUB(sub), .out_valid(out_valid), .out_ready(out_ready), .SUM(sum),
    .Cout(cout), .Overflow(ovf), .Zero(zero)
  );

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                      input logic ts, input exp_t e);
    int n;
    a = ta; b = tb; c0 = tc; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_wait", 64'(in_ready), 64'd1);
    else main_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [31:0] ra, rb;
    logic        rc, rs;
    ra = $urandom; rb = $urandom;
    rc = 1'($urandom_range(1)); rs = 1'($urandom_range(1));
    send(ra, rb, rc, rs, model(32, 64'(ra), 64'(rb), rc, rs));
  endtask

  task automatic check_idle();
    check("idle_out_valid", 64'(out_valid), 64'd0);
    check("idle_sum", 64'(sum), 64'd0);
    check("idle_cout", 64'(cout), 64'd0);
    check("idle_ovf", 64'(ovf), 64'd0);
    check("idle_zero", 64'(zero), 64'd0);
    check("idle_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && main_q.size() != 0; i++) @(posedge clk);
    check("drain", 64'(main_q.size()), 64'd0);
    #1;
  endtask

  // Output side of the main scoreboard; a stalled result is re-checked every cycle.
  always @(negedge clk) begin
    if (rst) begin
      main_q.delete();
    end else if (out_valid) begin
      if (main_q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        check("sum", 64'(sum), main_q[0].sum);
        check("cout", 64'(cout), 64'(main_q[0].cout));
        check("ovf", 64'(ovf), 64'(main_q[0].ovf));
        check("zero", 64'(zero), 64'(main_q[0].zero));
        if (!out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
        else void'(main_q.pop_front());
      end
    end
  end

  // ---------------- sweep instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : 64;
    localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : 8;
    logic         s_rst, s_iv, s_ir, s_c0, s_sub, s_ov, s_or, s_cout, s_ovf, s_zero, done;
    logic [W-1:0] s_a, s_b, s_sum;
    exp_t         q[$];
    exp_t         e;

    adder_pipe_nbit #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst(s_rst), .in_valid(s_iv), .in_ready(s_ir), .A(s_a), .B(s_b),
      .C0(s_c0), .SUB(s_sub), .out_valid(s_ov), .out_ready(s_or), .SUM(s_sum),
      .Cout(s_cout), .Overflow(s_ovf), .Zero(s_zero)
    );

    initial begin
      done = 1'b0; s_rst = 1'b1; s_iv = 1'b0; s_or = 1'b1;
      s_a = {W{1'b0}}; s_b = {W{1'b0}}; s_c0 = 1'b0; s_sub = 1'b0;
      repeat (2) @(posedge clk);
      #1 s_rst = 1'b0;
      for (int i = 0; i < 300; i++) begin
        s_iv  = ($urandom_range(3) != 0);
        s_or  = ($urandom_range(3) != 0);
        s_a   = W'({$urandom, $urandom});
        s_b   = W'({$urandom, $urandom});
        if ($urandom_range(7) == 0) s_a = {W{1'b1}};
        if ($urandom_range(7) == 0) s_b = {1'b0, {(W-1){1'b1}}};
        s_c0  = 1'($urandom_range(1));
        s_sub = 1'($urandom_range(1));
        @(posedge clk);
        #1;
      end
      s_iv = 1'b0;
      s_or = 1'b1;
      repeat (S + 4) @(posedge clk);
      check("sweep_drain", 64'(q.size()), 64'd0);
      done = 1'b1;
    end

    always @(negedge clk) begin
      if (!s_rst) begin
        if (s_ov && s_or) begin
          if (q.size() == 0) begin
            check("sweep_spurious", 64'(s_ov), 64'd0);
          end else begin
            e = q.pop_front();
            check("sweep_sum", 64'(s_sum), e.sum);
            check("sweep_cout", 64'(s_cout), 64'(e.cout));
            check("sweep_ovf", 64'(s_ovf), 64'(e.ovf));
            check("sweep_zero", 64'(s_zero), 64'(e.zero));
          end
        end
        if (s_iv && s_ir) q.push_back(model(W, 64'(s_a), 64'(s_b), s_c0, s_sub));
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = 32'd0; b = 32'd0; c0 = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle();
    @(posedge clk);
    #1;

    // Directed vectors; the first one alone also measures latency.
    send(32'h939B_9593, 32'h53D4_9755, 1'b1, 1'b0, mk(64'hE770_2CE9, 1'b0, 1'b0, 1'b0));
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("latency", 64'(lat), 64'd4);
    @(posedge clk);
    #1;
    send(32'h939B_91D3, 32'hD394_E6E5, 1'b0, 1'b0, mk(64'(T2_SUM), 1'b1, 1'b1, 1'b0));
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(64'(T3_SUM), 1'b0, 1'b1, 1'b0));
    send(32'd5, 32'd7, 1'b0, 1'b1, mk(64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    send(32'd7, 32'd7, 1'b1, 1'b1, mk(64'd0, 1'b1, 1'b0, 1'b1));
    wait_drain();

    // Back-to-back ops with the consumer stalling for three cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with three ops in flight: nothing of them may ever emerge.
    for (int i = 0; i < 3; i++) send_rand();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle();
    check("rst_flush", 64'(main_q.size()), 64'd0);
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send_rand();
    wait_drain();

    n = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("sweep_done", 64'(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
